// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int DRAIN_W = 16;
    localparam int WAIT_W  = 8;
    localparam int PERF_W  = 32;

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// EX-stage operand forwarding select for one source register.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] ex_mem_rd_i,
    input  logic       ex_mem_regwrite_i,
    input  logic [4:0] mem_wb_rd_i,
    input  logic       mem_wb_regwrite_i,
    output logic [1:0] fwd_o
);

    // The younger EX/MEM result takes precedence over MEM/WB.
    always_comb begin
        fwd_o = FWD_RF;
        if (ex_mem_regwrite_i && (ex_mem_rd_i != 5'd0) && (ex_mem_rd_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (mem_wb_regwrite_i && (mem_wb_rd_i != 5'd0) && (mem_wb_rd_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Optional performance counters are enabled with macro PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic [4:0]  ID_EX_rs1,
    input  logic [4:0]  ID_EX_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_MemRead,
    input  logic        PCSrc,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [4:0]  MEM_WB_rd,
    input  logic        EX_MEM_RegWrite,
    input  logic        MEM_WB_RegWrite,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cyc
`endif
);

    localparam int INIT_LAST = (INIT_CYCLES <= 1) ? 0 : INIT_CYCLES - 1;
    localparam int TIMEOUT_C = (MEM_TIMEOUT > 255) ? 255 : MEM_TIMEOUT;
    localparam logic [DRAIN_W-1:0] INIT_LAST_V = DRAIN_W'(INIT_LAST);
    localparam logic [WAIT_W-1:0]  TIMEOUT_V   = WAIT_W'(TIMEOUT_C);

    state_e              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;
    logic                memstall, load_use, wait_inc;

    assign memstall = dmem_req & ~dmem_ready;
    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        state_d  = state_q;
        drain_d  = drain_q;
        wait_d   = wait_q;
        wait_inc = 1'b0;
        case (state_q)
            INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
                if (drain_q == INIT_LAST_V) begin
                    state_d = RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            RUN: begin
                if (memstall) begin
                    {StallF, StallD, StallE, StallM} = 4'b1111;
                    FlushW   = 1'b1;
                    wait_inc = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (PCSrc) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MEM_WAIT: begin
                // A held redirect is deliberately ignored on the release cycle.
                if (memstall) begin
                    {StallF, StallD, StallE, StallM} = 4'b1111;
                    FlushW   = 1'b1;
                    wait_inc = 1'b1;
                end else begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            end
            default: state_d = INIT;
        endcase
        // The counter covers every stalled memory cycle, including the entry cycle in RUN.
        if (wait_inc) begin
            wait_d = sat_inc_wait(wait_q);
        end
        err_d = err_q | (wait_inc & (wait_d >= TIMEOUT_V));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            drain_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign mem_err = err_q;

    logic [4:0] fwd_rs  [2];
    logic [1:0] fwd_sel [2];

    assign fwd_rs[0] = ID_EX_rs1;
    assign fwd_rs[1] = ID_EX_rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        forward_unit u_fwd (
            .rs_i              (fwd_rs[gi]),
            .ex_mem_rd_i       (EX_MEM_rd),
            .ex_mem_regwrite_i (EX_MEM_RegWrite),
            .mem_wb_rd_i       (MEM_WB_rd),
            .mem_wb_regwrite_i (MEM_WB_RegWrite),
            .fwd_o             (fwd_sel[gi])
        );
    end

    assign ForwardAE = rst ? FWD_RF : fwd_sel[0];
    assign ForwardBE = rst ? FWD_RF : fwd_sel[1];

`ifdef PIPE_PERF_CNT_EN
    logic [2:0]        perf_inc;
    logic [PERF_W-1:0] perf_q [3];

    assign perf_inc[0] = StallF & (state_q != INIT);
    assign perf_inc[1] = (state_q == RUN) & ~memstall & PCSrc;
    assign perf_inc[2] = wait_inc;

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                perf_q[gi] <= '0;
            end else if (perf_inc[gi] && !(&perf_q[gi])) begin
                perf_q[gi] <= perf_q[gi] + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cyc   = perf_q[0];
    assign perf_flush_cnt   = perf_q[1];
    assign perf_memwait_cyc = perf_q[2];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs, a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic        ID_EX_MemRead, PCSrc;
    logic [4:0]  EX_MEM_rd, MEM_WB_rd;
    logic        EX_MEM_RegWrite, MEM_WB_RegWrite, dmem_req, dmem_ready;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0]  ForwardAE, ForwardBE;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .ID_EX_rs1       (ID_EX_rs1),
        .ID_EX_rs2       (ID_EX_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .PCSrc           (PCSrc),
        .EX_MEM_rd       (EX_MEM_rd),
        .MEM_WB_rd       (MEM_WB_rd),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .StallM          (StallM),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushW          (FlushW),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .mem_err         (mem_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_memwait_cyc(perf_memwait_cyc)
`endif
    );

    typedef struct {
        string       name;
        logic [11:0] exp;
        bit          perf_zero;
    } txn_t;

    txn_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn_no   = 0;

    wire [11:0] act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                       ForwardAE, ForwardBE, mem_err};

    // Field order: stalls F/D/E/M, flushes D/E/W, ForwardAE, ForwardBE, mem_err.
    function automatic logic [11:0] ex(input logic [3:0] s, input logic [2:0] f,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic e);
        return {s, f, a, b, e};
    endfunction

    always @(negedge clk) begin : monitor
        txn_t t;
        if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            txn_no++;
            checks++;
            if (act !== t.exp) begin
                failures++;
                $display("FAIL %s: got %b want %b (S FDEW order)", t.name, act, t.exp);
            end else begin
                $display("txn %0d %s ok %b", txn_no, t.name, act);
            end
`ifdef PIPE_PERF_CNT_EN
            if (t.perf_zero) begin
                checks++;
                if ({perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc} !== 96'd0) begin
                    failures++;
                    $display("FAIL %s_perf: got %0d/%0d/%0d want 0/0/0", t.name,
                             perf_stall_cyc, perf_flush_cnt, perf_memwait_cyc);
                end
            end
`endif
        end
    end

    task automatic clr();
        IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;
        ID_EX_rs1 = 5'd0; ID_EX_rs2 = 5'd0; ID_EX_rd = 5'd0;
        ID_EX_MemRead = 1'b0; PCSrc = 1'b0;
        EX_MEM_rd = 5'd0; MEM_WB_rd = 5'd0;
        EX_MEM_RegWrite = 1'b0; MEM_WB_RegWrite = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [11:0] e, input bit pz = 1'b0);
        txn_t t;
        t.name = nm;
        t.exp = e;
        t.perf_zero = pz;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;
        cyc("reset0", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0), 1'b1);
        cyc("reset1", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0));
        rst = 1'b0;
        cyc("drain0", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0));
        cyc("drain1", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0));
        cyc("run_idle", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));

        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5;
        cyc("loaduse_rs2", ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0));
        clr();
        cyc("lu_bubble", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd9; IF_ID_rs1 = 5'd9;
        cyc("loaduse_rs1", ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0));
        clr();
        ID_EX_MemRead = 1'b1;
        cyc("lu_x0", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
        ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5;
        cyc("no_load", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));

        ID_EX_MemRead = 1'b1; PCSrc = 1'b1;
        cyc("redir_over_lu", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
        clr();
        PCSrc = 1'b1;
        cyc("redir_only", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0));
        clr();

        EX_MEM_rd = 5'd7; MEM_WB_rd = 5'd7; EX_MEM_RegWrite = 1'b1; MEM_WB_RegWrite = 1'b1;
        ID_EX_rs1 = 5'd7;
        cyc("fwd_both", ex(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0));
        EX_MEM_rd = 5'd0;
        cyc("fwd_wb", ex(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0));
        MEM_WB_rd = 5'd0; ID_EX_rs1 = 5'd0;
        cyc("fwd_x0", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));
        ID_EX_rs1 = 5'd3; ID_EX_rs2 = 5'd12;
        EX_MEM_rd = 5'd12; EX_MEM_RegWrite = 1'b0; MEM_WB_rd = 5'd12;
        cyc("fwdB_wb", ex(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0));
        EX_MEM_RegWrite = 1'b1;
        cyc("fwdB_mem", ex(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0));
        clr();

        dmem_req = 1'b1;
        cyc("mw1", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
        cyc("mw2", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0));
        cyc("mw3", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1));
        dmem_ready = 1'b1;
        cyc("mw_release", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));
        dmem_req = 1'b0;
        cyc("ready_noreq", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));

        dmem_req = 1'b1; dmem_ready = 1'b0; PCSrc = 1'b1;
        cyc("mw_pc_hold", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1));
        dmem_ready = 1'b1;
        cyc("mw_pc_release", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1));
        dmem_req = 1'b0; dmem_ready = 1'b0;
        cyc("pc_after_wait", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b1));
        clr();

        dmem_req = 1'b1;
        cyc("rw1", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1));
        cyc("rw2", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1));
        rst = 1'b1;
        cyc("rst_mid_wait", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0), 1'b1);
        rst = 1'b0;
        cyc("redrain0", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0));
        cyc("redrain1", ex(4'b1000, 3'b111, 2'b00, 2'b00, 1'b0));
        dmem_req = 1'b0;
        cyc("rerun", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0));

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got running want finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the EX-stage forwarding selects. It handles:
- load-use stalls;
- redirects from `PCSrc` (branch taken, JAL, JALR);
- data-memory wait states;
- a post-reset pipeline drain.

It sits beside the stage registers and has no datapath of its own.

## Interface
Parameters:
- `INIT_CYCLES`, default 2: number of drain cycles after reset deassertion.
- `MEM_TIMEOUT`, default 255: number of consecutive memory-wait cycles before `mem_err` sets. The counter is 8 bits wide.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IF_ID_rs1`, `IF_ID_rs2`  in  5  source registers of the instruction in decode.
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd`  in  5  register fields held in ID/EX.
- `ID_EX_MemRead`  in  1  the instruction in EX is a load.
- `PCSrc`  in  1  control redirect resolved in EX.
- `EX_MEM_rd`, `MEM_WB_rd`  in  5  destination registers in MEM and WB.
- `EX_MEM_RegWrite`, `MEM_WB_RegWrite`  in  1  write enables in MEM and WB.
- `dmem_req`  in  1  the MEM stage is accessing data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW`  out  1  insert a bubble into IF/ID, ID/EX and MEM/WB.
- `ForwardAE`, `ForwardBE`  out  2  ALU operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `mem_err`  out  1  sticky flag: memory-wait timeout reached.

## Operation
FSM states are `INIT`, `RUN` and `MEM_WAIT`.

**Reset state (while `rst` is high):**
- FSM in `INIT`, drain counter = 0, wait counter = 0, `mem_err` = 0.
- Outputs: `StallF`=1, `FlushD`=1, `FlushE`=1, `FlushW`=1; every other stall = 0; forwarding selects = 00.

**`INIT`:**
- Outputs are identical to the reset values.
- The drain counter increments each cycle. When it reaches `INIT_CYCLES-1`, the next state is `RUN`.
- If `INIT_CYCLES` is 0, treat it as 1.

**`RUN`:** the following conditions are evaluated combinationally, in priority order.
1. **Memory wait** (`memstall = dmem_req & ~dmem_ready`):
   - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
   - All other flushes = 0.
   - Next state is `MEM_WAIT`.
2. **Redirect** (`PCSrc` = 1):
   - `FlushD` = 1 and `FlushE` = 1.
   - The load-use check is suppressed, because the decode instruction is on the wrong path.
3. **Load-use:**
   - Condition: `ID_EX_MemRead` & `ID_EX_rd`≠0 & (`ID_EX_rd`==`IF_ID_rs1` | `ID_EX_rd`==`IF_ID_rs2`).
   - Response: `StallF`=1, `StallD`=1, `FlushE`=1 for exactly one cycle. The bubble then clears the condition.
4. **Otherwise:** all stalls and flushes are 0.

**`MEM_WAIT`:**
- The outputs of case 1 apply while `memstall` is high.
- The wait counter increments each cycle and saturates at 255.
- When the counter reaches `MEM_TIMEOUT`, `mem_err` sets and stays set until reset. The FSM keeps waiting.
- The cycle in which `dmem_ready`=1: all stalls release in that same cycle, the next state is `RUN`, and the wait counter clears.
- A `PCSrc` held in EX during the wait takes effect in the first `RUN` cycle after the wait.

**Forwarding** (applies in every state; A shown, B uses `ID_EX_rs2`):
- 10 if `EX_MEM_RegWrite` & `EX_MEM_rd`≠0 & `EX_MEM_rd`==`ID_EX_rs1`.
- Otherwise 01 if the same condition holds for the MEM/WB fields.
- Otherwise 00.
- When EX/MEM and MEM/WB both match, 10 wins.

## Timing
- Stall, flush and forward outputs are combinational from the current state and the inputs, giving zero-cycle response. The stage registers sample them on the next edge.
- FSM state, drain counter, wait counter and `mem_err` are registered.
- Load-use costs 1 bubble. A redirect costs 2 bubbles.
- A memory access costs N stall cycles, where N is the number of cycles with `dmem_ready` low.
- Asserting `rst` mid-`MEM_WAIT` forces `INIT` immediately; deasserting it restarts the drain.
- `dmem_ready` high while `dmem_req` is low is ignored.

## Configuration
Macro `PIPE_PERF_CNT_EN`:
- **Defined:** adds three 32-bit outputs.
  - `perf_stall_cyc`: increments in any cycle where `StallF` is high in `RUN` or `MEM_WAIT`.
  - `perf_flush_cnt`: increments once per redirect.
  - `perf_memwait_cyc`: increments each `memstall` cycle.
  - All three saturate at 0xFFFFFFFF and clear on `rst`.
- **Undefined:** these ports and counters do not exist.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (`INIT`, `RUN`, `MEM_WAIT`);
  - the forward-select constants `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - the counter widths.
- Sub-module `forward_unit`: combinational, instantiated twice, once for operand A and once for operand B.

## Test plan
- **Reset drain:** with `INIT_CYCLES`=2, deassert `rst` → `StallF`/`FlushD`/`FlushE` stay 1 for 2 cycles, then 0 in `RUN`.
- **Load-use:** `ID_EX_MemRead`=1, `ID_EX_rd`=5, `IF_ID_rs2`=5 → exactly one cycle of `StallF`=`StallD`=`FlushE`=1.
- **Redirect over load-use:** apply the load-use condition above together with `PCSrc`=1 → `FlushD`=`FlushE`=1 and `StallF`=0.
- **Memory wait:** `dmem_req`=1 with `dmem_ready` low for 3 cycles → 3 cycles of all stalls plus `FlushW`, released in the cycle `dmem_ready`=1. With `MEM_TIMEOUT`=2, `mem_err`=1 stays set.
- **Forwarding priority:** `EX_MEM_rd`=`MEM_WB_rd`=7, both RegWrite=1, `ID_EX_rs1`=7 → `ForwardAE`=10. With `EX_MEM_rd`=0 instead → 01. With rd=x0 in both → 00.
- **Reset mid-wait:** assert `rst` during `MEM_WAIT` → outputs return to reset values immediately, `mem_err`=0, and the perf counters (when enabled) read 0.
